pixel_seq_ctrl: RTL and testbench

PIXEL_SEQ_CTRL -- requirements
Module: pixel_seq_ctrl

---
 rtl/pixel_seq_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pixel_seq_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_seq_ctrl.sv
// Pixel reset/store sequencer with memory-select stepping and readout column select.
// Optional build macro PIX_SEQ_RUN_CNT_EN adds a 16-bit completed-sequence counter on RUN_CNT.
module pixel_seq_ctrl #(
  parameter int CNT_W = 8,
  parameter int N_MEM = 16,
  parameter int N_COL = 4,
  localparam int MW = $clog2(N_MEM) + 1
) (
  input  logic               CLK,
  input  logic               NRST_X,
  input  logic               PIX_RESET,
  input  logic               PIX_STORE,
  input  logic               PIX_ABORT,
  input  logic               TRG_MODE,
  input  logic               TRG_DET,
  input  logic               EVT_NUM_END,
  input  logic               COMP_EN_SEL,
  input  logic [5*CNT_W-1:0] TIMING,
  input  logic               MEM_SET_EN,
  input  logic               MEM_SET_CLR,
  input  logic               REGOUT_EN,
  input  logic [MW-1:0]      READ_MEM,
  output logic               CF_RST,
  output logic               CDS_RST,
  output logic               RST_COMP1,
  output logic               RST_COMP2,
  output logic               SEL_RST_VTH,
  output logic               COMP_EN,
  output logic               PIX_RESET_BUSY,
  output logic               PIX_END,
  output logic               MEM_SET_DONE,
  output logic               LAST_MEM,
  output logic               AOUT_SEL,
  output logic               TOUT_SEL,
  output logic [N_COL-1:0]   COLOUT_SEL,
  output logic [15:0]        RUN_CNT
);

  localparam logic [MW-1:0] NMEM_V = MW'(N_MEM);
  localparam logic [MW-1:0] ONE_V  = MW'(1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;
  state_t r_state, w_nextState;

  logic [CNT_W-1:0] r_cnt, r_tCf, r_tC1, r_tC2, r_tVth, r_tCds;
  logic r_pixStoreD, r_cf, r_c1, r_c2, r_vthN, r_cds, r_pixEnd;
  logic r_compAlways, r_compMask;
  logic w_idle, w_run, w_start, w_flagEn;

  assign w_idle  = (r_state == ST_IDLE);
  assign w_run   = (r_state == ST_RUN);
  assign w_start = w_idle & ~PIX_ABORT &
                   ((PIX_RESET & PIX_STORE) | (TRG_MODE & PIX_STORE & ~r_pixStoreD));

  always_comb begin
    w_nextState    = r_state;
    PIX_RESET_BUSY = 1'b0;
    case (r_state)
      ST_IDLE: if (w_start) w_nextState = ST_RUN;
      ST_RUN: begin
        PIX_RESET_BUSY = 1'b1;
        if (PIX_ABORT || r_pixEnd) w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Flags only follow the counter while the sequence is continuing, so an abort or the final edge drops them.
  assign w_flagEn = w_run & (w_nextState == ST_RUN);

  always_ff @(posedge CLK or negedge NRST_X) begin
    if (!NRST_X) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_pixStoreD <= 1'b0;
      r_tCf       <= '0;
      r_tC1       <= '0;
      r_tC2       <= '0;
      r_tVth      <= '0;
      r_tCds      <= '0;
      r_cf        <= 1'b0;
      r_c1        <= 1'b0;
      r_c2        <= 1'b0;
      r_vthN      <= 1'b0;
      r_cds       <= 1'b0;
      r_pixEnd    <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_cnt       <= w_run ? r_cnt + 1'b1 : '0;
      r_pixStoreD <= PIX_STORE;
      if (w_start) begin
        r_tCf  <= TIMING[0*CNT_W +: CNT_W];
        r_tC1  <= TIMING[1*CNT_W +: CNT_W];
        r_tC2  <= TIMING[2*CNT_W +: CNT_W];
        r_tVth <= TIMING[3*CNT_W +: CNT_W];
        r_tCds <= TIMING[4*CNT_W +: CNT_W];
      end
      r_cf     <= w_flagEn & (r_cnt < r_tCf);
      r_c1     <= w_flagEn & (r_cnt < r_tC1) & ~TRG_MODE;
      r_c2     <= w_flagEn & (r_cnt < r_tC2) & ~TRG_MODE;
      r_vthN   <= w_flagEn & (r_cnt < r_tVth) & ~TRG_MODE;
      r_cds    <= w_flagEn & (r_cnt < r_tCds);
      r_pixEnd <= w_flagEn & (r_cnt == r_tCds);
    end
  end

  always_ff @(posedge CLK or negedge NRST_X) begin
    if (!NRST_X) begin
      r_compAlways <= 1'b0;
      r_compMask   <= 1'b0;
    end else begin
      if (w_run && (r_cnt == r_tCds) && PIX_STORE) r_compAlways <= 1'b1;
      else if (w_idle && PIX_RESET)                r_compAlways <= 1'b0;
      if (!PIX_STORE)   r_compMask <= 1'b0;
      else if (w_start) r_compMask <= 1'b1;
    end
  end

  assign CF_RST      = PIX_STORE ? r_cf : 1'b1;
  assign CDS_RST     = PIX_STORE ? r_cds : 1'b1;
  assign RST_COMP1   = PIX_STORE & r_c1;
  assign RST_COMP2   = PIX_STORE & r_c2;
  assign SEL_RST_VTH = PIX_STORE ? ~r_vthN : 1'b1;
  assign PIX_END     = r_pixEnd;
  assign COMP_EN     = TRG_MODE ? (TRG_DET & r_compMask & w_start & ~EVT_NUM_END)
                                : (COMP_EN_SEL ? r_compAlways : (r_compMask & w_start));

  logic [MW-1:0] r_memCnt, w_readEff;
  logic r_memSetEnD, r_memSetDone, w_memRise, w_lastMem;

  always_comb begin
    w_readEff = READ_MEM;
    if (READ_MEM > NMEM_V)     w_readEff = NMEM_V;
    else if (READ_MEM == '0)   w_readEff = ONE_V;
  end

  assign w_memRise = MEM_SET_EN & ~r_memSetEnD;
  assign w_lastMem = (r_memCnt == w_readEff - ONE_V);

  always_ff @(posedge CLK or negedge NRST_X) begin
    if (!NRST_X) begin
      r_memCnt     <= '0;
      r_memSetEnD  <= 1'b0;
      r_memSetDone <= 1'b0;
    end else begin
      r_memSetEnD  <= MEM_SET_EN;
      r_memSetDone <= w_memRise;
      if (MEM_SET_CLR)                  r_memCnt <= '0;
      else if (w_memRise && !w_lastMem) r_memCnt <= r_memCnt + ONE_V;
    end
  end

  assign MEM_SET_DONE = r_memSetDone;
  assign LAST_MEM     = w_lastMem;
  assign AOUT_SEL     = ~r_memCnt[0] & ~REGOUT_EN;
  assign TOUT_SEL     = r_memCnt[0] & ~REGOUT_EN;

  // Each column group holds two memories (analog/timing pair); groups past N_COL select nothing.
  always_comb begin
    COLOUT_SEL = '0;
    for (int i = 0; i < N_COL; i++)
      if (int'(r_memCnt[MW-1:1]) == i) COLOUT_SEL[i] = 1'b1;
  end

`ifdef PIX_SEQ_RUN_CNT_EN
  logic [15:0] r_runCnt;
  always_ff @(posedge CLK or negedge NRST_X) begin
    if (!NRST_X)       r_runCnt <= '0;
    else if (r_pixEnd) r_runCnt <= r_runCnt + 16'd1;
  end
  assign RUN_CNT = r_runCnt;
`else
  assign RUN_CNT = 16'd0;
`endif

endmodule

// File: tb/tb_pixel_seq_ctrl.sv
// Self-checking bench for pixel_seq_ctrl: vector table for memory stepping, offset-based sequence model,
// randomized sequences and memory traffic, plus hand-written abort/reset corner cases.
module tb_pixel_seq_ctrl;
  localparam int CNT_W = 8;
  localparam int N_MEM = 16;
  localparam int N_COL = 4;
  localparam int MW    = 5;

  logic CLK = 1'b0;
  logic NRST_X = 1'b0;
  logic PIX_RESET = 1'b0, PIX_STORE = 1'b0, PIX_ABORT = 1'b0;
  logic TRG_MODE = 1'b0, TRG_DET = 1'b0, EVT_NUM_END = 1'b0, COMP_EN_SEL = 1'b0;
  logic [5*CNT_W-1:0] TIMING = '0;
  logic MEM_SET_EN = 1'b0, MEM_SET_CLR = 1'b0, REGOUT_EN = 1'b0;
  logic [MW-1:0] READ_MEM = 5'd3;
  logic CF_RST, CDS_RST, RST_COMP1, RST_COMP2, SEL_RST_VTH, COMP_EN;
  logic PIX_RESET_BUSY, PIX_END, MEM_SET_DONE, LAST_MEM, AOUT_SEL, TOUT_SEL;
  logic [N_COL-1:0] COLOUT_SEL;
  logic [15:0] RUN_CNT;

  int checkCnt = 0;
  int passCnt = 0;
  bit maskM = 1'b0;
  bit alwaysM = 1'b0;
  int runCntM = 0;
  int memCntM = 0;
  bit memPrevM = 1'b0;

  typedef struct {
    logic en, clr, regout;
    logic [MW-1:0] readMem;
    logic last, aout, tout, done;
    logic [N_COL-1:0] col;
  } memVec_t;

  pixel_seq_ctrl #(.CNT_W(CNT_W), .N_MEM(N_MEM), .N_COL(N_COL)) dut (
    .CLK(CLK), .NRST_X(NRST_X), .PIX_RESET(PIX_RESET), .PIX_STORE(PIX_STORE), .PIX_ABORT(PIX_ABORT),
    .TRG_MODE(TRG_MODE), .TRG_DET(TRG_DET), .EVT_NUM_END(EVT_NUM_END), .COMP_EN_SEL(COMP_EN_SEL),
    .TIMING(TIMING), .MEM_SET_EN(MEM_SET_EN), .MEM_SET_CLR(MEM_SET_CLR), .REGOUT_EN(REGOUT_EN),
    .READ_MEM(READ_MEM), .CF_RST(CF_RST), .CDS_RST(CDS_RST), .RST_COMP1(RST_COMP1),
    .RST_COMP2(RST_COMP2), .SEL_RST_VTH(SEL_RST_VTH), .COMP_EN(COMP_EN),
    .PIX_RESET_BUSY(PIX_RESET_BUSY), .PIX_END(PIX_END), .MEM_SET_DONE(MEM_SET_DONE),
    .LAST_MEM(LAST_MEM), .AOUT_SEL(AOUT_SEL), .TOUT_SEL(TOUT_SEL), .COLOUT_SEL(COLOUT_SEL),
    .RUN_CNT(RUN_CNT)
  );

  always #20 CLK = ~CLK;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCnt++;
    if (actual == expected) passCnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic en, input logic clr, input logic regout, input logic [MW-1:0] rm);
    @(negedge CLK);
    MEM_SET_EN = en;
    MEM_SET_CLR = clr;
    REGOUT_EN = regout;
    READ_MEM = rm;
    @(posedge CLK);
    #1;
  endtask

  function automatic int lastIdxOf(input int rm);
    int e;
    e = (rm > N_MEM) ? N_MEM : rm;
    if (e == 0) e = 1;
    return e - 1;
  endfunction

  function automatic int colOf(input int cnt);
    return (cnt / 2 < N_COL) ? (1 << (cnt / 2)) : 0;
  endfunction

  // Expected outputs at cycle offset k from the start cycle: RUN spans k=1..lastRun with c=k-1,
  // and each drive flag seen at cycle k reflects the counter value c=k-2.
  task automatic runSeq(input int tcf, input int tc1, input int tc2, input int tvth, input int tcds,
                        input bit trg, input bit det, input bit evt, input int abortAt, input bit sel,
                        output int nCf, output int nC1, output int nC2, output int nVthLow,
                        output int nCds, output int nBusy, output int nEnd);
    int lastRun, j;
    bit inRun, flag, endExp;
    nCf = 0; nC1 = 0; nC2 = 0; nVthLow = 0; nCds = 0; nBusy = 0; nEnd = 0;
    if (trg) begin
      @(negedge CLK);
      TRG_MODE = 1'b1;
      PIX_STORE = 1'b0;
      PIX_RESET = 1'b0;
      maskM = 1'b0;
    end
    @(negedge CLK);
    TRG_MODE = trg;
    PIX_STORE = 1'b1;
    PIX_RESET = ~trg;
    TRG_DET = det;
    EVT_NUM_END = evt;
    COMP_EN_SEL = sel;
    TIMING = {8'(tcds), 8'(tvth), 8'(tc2), 8'(tc1), 8'(tcf)};
    #1;
    checkOutput("COMP_EN at start", int'(COMP_EN),
                trg ? int'(det & maskM & ~evt) : (sel ? int'(alwaysM) : int'(maskM)));
    maskM = 1'b1;
    if (!trg) alwaysM = 1'b0;
    lastRun = (abortAt >= 0) ? abortAt + 1 : tcds + 2;
    for (int k = 1; k <= lastRun + 2; k++) begin
      @(posedge CLK);
      #1;
      inRun = (k <= lastRun);
      flag = (k >= 2) && (k <= lastRun);
      j = k - 2;
      endExp = (abortAt < 0) && (k == tcds + 2);
      checkOutput($sformatf("BUSY k=%0d", k), int'(PIX_RESET_BUSY), int'(inRun));
      checkOutput($sformatf("CF_RST k=%0d", k), int'(CF_RST), int'(flag && j < tcf));
      checkOutput($sformatf("RST_COMP1 k=%0d", k), int'(RST_COMP1), int'(flag && j < tc1 && !trg));
      checkOutput($sformatf("RST_COMP2 k=%0d", k), int'(RST_COMP2), int'(flag && j < tc2 && !trg));
      checkOutput($sformatf("SEL_RST_VTH k=%0d", k), int'(SEL_RST_VTH), int'(!(flag && j < tvth && !trg)));
      checkOutput($sformatf("CDS_RST k=%0d", k), int'(CDS_RST), int'(flag && j < tcds));
      checkOutput($sformatf("PIX_END k=%0d", k), int'(PIX_END), int'(endExp));
      checkOutput($sformatf("RUN_CNT k=%0d", k), int'(RUN_CNT), runCntM);
      nCf += int'(CF_RST);
      nC1 += int'(RST_COMP1);
      nC2 += int'(RST_COMP2);
      nVthLow += int'(!SEL_RST_VTH);
      nCds += int'(CDS_RST);
      nBusy += int'(PIX_RESET_BUSY);
      nEnd += int'(PIX_END);
      if (endExp) begin
`ifdef PIX_SEQ_RUN_CNT_EN
        runCntM = (runCntM + 1) % 65536;
`endif
      end
      @(negedge CLK);
      PIX_RESET = 1'b0;
      TIMING = {$urandom, $urandom};
      PIX_ABORT = (k == abortAt + 1);
    end
    PIX_ABORT = 1'b0;
    if (abortAt < 0) alwaysM = 1'b1;
  endtask

  initial begin
    memVec_t memTab[16];
    int nCf, nC1, nC2, nVthLow, nCds, nBusy, nEnd;
    int rm, tcds, abortAt;
    bit en, clr, regout, rise;

    // en clr regout readMem | last aout tout done col
    memTab[0]  = '{0, 0, 0, 3,  0, 1, 0, 0, 4'b0001};
    memTab[1]  = '{1, 0, 0, 3,  0, 0, 1, 1, 4'b0001};
    memTab[2]  = '{0, 0, 0, 3,  0, 0, 1, 0, 4'b0001};
    memTab[3]  = '{1, 0, 0, 3,  1, 1, 0, 1, 4'b0010};
    memTab[4]  = '{0, 0, 0, 3,  1, 1, 0, 0, 4'b0010};
    memTab[5]  = '{1, 0, 0, 3,  1, 1, 0, 1, 4'b0010};
    memTab[6]  = '{1, 0, 0, 3,  1, 1, 0, 0, 4'b0010};
    memTab[7]  = '{0, 0, 0, 3,  1, 1, 0, 0, 4'b0010};
    memTab[8]  = '{1, 0, 0, 3,  1, 1, 0, 1, 4'b0010};
    memTab[9]  = '{0, 0, 0, 3,  1, 1, 0, 0, 4'b0010};
    memTab[10] = '{1, 1, 0, 3,  0, 1, 0, 1, 4'b0001};
    memTab[11] = '{0, 0, 0, 0,  1, 1, 0, 0, 4'b0001};
    memTab[12] = '{1, 0, 0, 0,  1, 1, 0, 1, 4'b0001};
    memTab[13] = '{0, 0, 0, 20, 0, 1, 0, 0, 4'b0001};
    memTab[14] = '{0, 0, 1, 20, 0, 0, 0, 0, 4'b0001};
    memTab[15] = '{1, 0, 1, 20, 0, 0, 0, 1, 4'b0001};

    PIX_STORE = 1'b1;
    #50;
    checkOutput("reset BUSY", int'(PIX_RESET_BUSY), 0);
    checkOutput("reset CF_RST", int'(CF_RST), 0);
    checkOutput("reset CDS_RST", int'(CDS_RST), 0);
    checkOutput("reset RST_COMP1", int'(RST_COMP1), 0);
    checkOutput("reset RST_COMP2", int'(RST_COMP2), 0);
    checkOutput("reset SEL_RST_VTH", int'(SEL_RST_VTH), 1);
    checkOutput("reset PIX_END", int'(PIX_END), 0);
    checkOutput("reset RUN_CNT", int'(RUN_CNT), 0);
    checkOutput("reset COMP_EN", int'(COMP_EN), 0);
    checkOutput("reset MEM_SET_DONE", int'(MEM_SET_DONE), 0);
    checkOutput("reset LAST_MEM", int'(LAST_MEM), 0);
    checkOutput("reset AOUT_SEL", int'(AOUT_SEL), 1);
    checkOutput("reset TOUT_SEL", int'(TOUT_SEL), 0);
    checkOutput("reset COLOUT_SEL", int'(COLOUT_SEL), 1);
    @(negedge CLK);
    NRST_X = 1'b1;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(memTab[i].en, memTab[i].clr, memTab[i].regout, memTab[i].readMem);
      memPrevM = memTab[i].en;
      checkOutput($sformatf("vec%0d LAST_MEM", i), int'(LAST_MEM), int'(memTab[i].last));
      checkOutput($sformatf("vec%0d AOUT_SEL", i), int'(AOUT_SEL), int'(memTab[i].aout));
      checkOutput($sformatf("vec%0d TOUT_SEL", i), int'(TOUT_SEL), int'(memTab[i].tout));
      checkOutput($sformatf("vec%0d MEM_SET_DONE", i), int'(MEM_SET_DONE), int'(memTab[i].done));
      checkOutput($sformatf("vec%0d COLOUT_SEL", i), int'(COLOUT_SEL), int'(memTab[i].col));
    end

    rm = 3;
    for (int cyc = 0; cyc < 240; cyc++) begin
      if (cyc % 40 == 0) begin
        rm = $urandom_range(0, 31);
        clr = 1'b1;
        en = 1'b0;
      end else begin
        clr = ($urandom_range(0, 19) == 0);
        en = $urandom_range(0, 1);
      end
      regout = ($urandom_range(0, 3) == 0);
      rise = en & ~memPrevM;
      if (clr) memCntM = 0;
      else if (rise && memCntM != lastIdxOf(rm)) memCntM = (memCntM + 1) % 32;
      memPrevM = en;
      applyStimulus(en, clr, regout, 5'(rm));
      checkOutput($sformatf("rnd%0d LAST_MEM", cyc), int'(LAST_MEM), int'(memCntM == lastIdxOf(rm)));
      checkOutput($sformatf("rnd%0d AOUT_SEL", cyc), int'(AOUT_SEL), int'(memCntM % 2 == 0 && !regout));
      checkOutput($sformatf("rnd%0d TOUT_SEL", cyc), int'(TOUT_SEL), int'(memCntM % 2 == 1 && !regout));
      checkOutput($sformatf("rnd%0d MEM_SET_DONE", cyc), int'(MEM_SET_DONE), int'(rise));
      checkOutput($sformatf("rnd%0d COLOUT_SEL", cyc), int'(COLOUT_SEL), colOf(memCntM));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd3);

    runSeq(10, 15, 20, 25, 35, 0, 0, 0, -1, 0, nCf, nC1, nC2, nVthLow, nCds, nBusy, nEnd);
    checkOutput("basic CF_RST cycles", nCf, 10);
    checkOutput("basic RST_COMP1 cycles", nC1, 15);
    checkOutput("basic RST_COMP2 cycles", nC2, 20);
    checkOutput("basic SEL_RST_VTH low cycles", nVthLow, 25);
    checkOutput("basic CDS_RST cycles", nCds, 35);
    checkOutput("basic BUSY cycles", nBusy, 37);
    checkOutput("basic PIX_END pulses", nEnd, 1);

    runSeq(10, 15, 20, 25, 35, 1, 1, 1, -1, 0, nCf, nC1, nC2, nVthLow, nCds, nBusy, nEnd);
    checkOutput("trig CF_RST cycles", nCf, 10);
    checkOutput("trig RST_COMP1 cycles", nC1, 0);
    checkOutput("trig RST_COMP2 cycles", nC2, 0);
    checkOutput("trig SEL_RST_VTH low cycles", nVthLow, 0);
    checkOutput("trig PIX_END pulses", nEnd, 1);

    runSeq(10, 15, 20, 25, 35, 0, 0, 0, 5, 0, nCf, nC1, nC2, nVthLow, nCds, nBusy, nEnd);
    checkOutput("abort BUSY cycles", nBusy, 6);
    checkOutput("abort PIX_END pulses", nEnd, 0);

    runSeq(3, 4, 5, 6, 8, 0, 0, 0, -1, 0, nCf, nC1, nC2, nVthLow, nCds, nBusy, nEnd);
    runSeq(3, 4, 5, 6, 8, 0, 0, 0, -1, 1, nCf, nC1, nC2, nVthLow, nCds, nBusy, nEnd);

    @(negedge CLK);
    TRG_MODE = 1'b0;
    PIX_RESET = 1'b1;
    PIX_ABORT = 1'b1;
    @(posedge CLK);
    #1;
    checkOutput("abort over start BUSY", int'(PIX_RESET_BUSY), 0);
    @(negedge CLK);
    PIX_RESET = 1'b0;
    PIX_ABORT = 1'b0;
    alwaysM = 1'b0;
    @(posedge CLK);
    #1;
    checkOutput("abort over start BUSY later", int'(PIX_RESET_BUSY), 0);

    for (int s = 0; s < 24; s++) begin
      tcds = $urandom_range(1, 30);
      abortAt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, tcds - 1) : -1;
      runSeq($urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 40),
             tcds, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             abortAt, 1'($urandom_range(0, 1)), nCf, nC1, nC2, nVthLow, nCds, nBusy, nEnd);
    end

    @(negedge CLK);
    TRG_MODE = 1'b0;
    PIX_STORE = 1'b1;
    PIX_RESET = 1'b1;
    TIMING = {8'd20, 8'd10, 8'd10, 8'd10, 8'd10};
    @(negedge CLK);
    PIX_RESET = 1'b0;
    repeat (4) @(negedge CLK);
    #1;
    checkOutput("midrun BUSY before reset", int'(PIX_RESET_BUSY), 1);
    NRST_X = 1'b0;
    #1;
    checkOutput("midrun reset BUSY", int'(PIX_RESET_BUSY), 0);
    checkOutput("midrun reset PIX_END", int'(PIX_END), 0);
    checkOutput("midrun reset CF_RST", int'(CF_RST), 0);
    checkOutput("midrun reset SEL_RST_VTH", int'(SEL_RST_VTH), 1);
    checkOutput("midrun reset RUN_CNT", int'(RUN_CNT), 0);
    @(negedge CLK);
    NRST_X = 1'b1;
    runCntM = 0;
    maskM = 1'b0;
    alwaysM = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge CLK);
      #1;
      checkOutput($sformatf("after reset PIX_END k=%0d", k), int'(PIX_END), 0);
      checkOutput($sformatf("after reset BUSY k=%0d", k), int'(PIX_RESET_BUSY), 0);
    end

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
